// File: rtl/general_register_bank_pkg.sv
// rtl/general_register_bank_pkg.sv - shared constants and helpers for the general register bank
//
// Purpose: default geometry, busy-bit state encoding, byte-count and byte-merge helpers.
// Ports: none (package).

package general_register_bank_pkg;

  localparam int GRB_DEFAULT_DATA_WIDTH = 32;
  localparam int GRB_DEFAULT_ADDR_WIDTH = 5;
  localparam int GRB_DEFAULT_NUM_READ   = 2;
  localparam int GRB_BYTE_WIDTH         = 8;

  // Each register's busy bit is a two-state machine.
  localparam logic [0:0] BUSY_IDLE    = 1'b0;
  localparam logic [0:0] BUSY_PENDING = 1'b1;

  // Number of byte lanes in a register of the given width.
  function automatic int grb_num_bytes(input int data_width);
    return data_width / GRB_BYTE_WIDTH;
  endfunction

  // Byte merge for one lane: take the new byte when its enable is set.
  function automatic logic [GRB_BYTE_WIDTH-1:0] merge_byte(
    input logic [GRB_BYTE_WIDTH-1:0] old_byte,
    input logic [GRB_BYTE_WIDTH-1:0] new_byte,
    input logic                      mask
  );
    return mask ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/general_register_bank_if.sv
// rtl/general_register_bank_if.sv - decode/writeback bus of the general register bank
//
// Purpose: groups the read, write and busy-set signals of the register bank.
// Ports (signals):
//   ReadAddresses / ReadData / ReadBusy  - NUM_READ packed read ports
//   WriteControl / WriteRegAddress / DataOfWrite / WriteByteEnable - write port, also clears busy
//   BusySetControl / BusySetAddress      - marks a register pending
//   BusyCount / AnyBusy                  - live scoreboard occupancy
// Modports: master = decode/writeback side, slave = register bank.

interface general_register_bank_if
  import general_register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = GRB_DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = GRB_DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = GRB_DEFAULT_NUM_READ
);

  logic [NUM_READ*ADDR_WIDTH-1:0]          ReadAddresses;
  logic [NUM_READ*DATA_WIDTH-1:0]          ReadData;
  logic [NUM_READ-1:0]                     ReadBusy;
  logic                                    WriteControl;
  logic [ADDR_WIDTH-1:0]                   WriteRegAddress;
  logic [DATA_WIDTH-1:0]                   DataOfWrite;
  logic [grb_num_bytes(DATA_WIDTH)-1:0]    WriteByteEnable;
  logic                                    BusySetControl;
  logic [ADDR_WIDTH-1:0]                   BusySetAddress;
  logic [ADDR_WIDTH:0]                     BusyCount;
  logic                                    AnyBusy;

  modport master (
    output ReadAddresses, WriteControl, WriteRegAddress, DataOfWrite, WriteByteEnable,
           BusySetControl, BusySetAddress,
    input  ReadData, ReadBusy, BusyCount, AnyBusy
  );

  modport slave (
    input  ReadAddresses, WriteControl, WriteRegAddress, DataOfWrite, WriteByteEnable,
           BusySetControl, BusySetAddress,
    output ReadData, ReadBusy, BusyCount, AnyBusy
  );

endinterface

// File: rtl/general_register_bank_busy_scoreboard.sv
// rtl/general_register_bank_busy_scoreboard.sv - per-register pending-producer scoreboard
//
// Purpose: busy vector, same-cycle write bypass for ReadBusy, live busy count.
// Ports:
//   clk, resetn            - clock, synchronous active-low reset
//   read_addr              - packed read addresses (NUM_READ ports)
//   write_en, write_addr   - writeback; clears busy of the written register
//   set_en, set_addr       - marks a register pending
//   read_busy              - per-port busy of the addressed register
//   busy_count, any_busy   - number of pending registers and its non-zero flag

module general_register_bank_busy_scoreboard
  import general_register_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = GRB_DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = GRB_DEFAULT_NUM_READ,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
  input  logic                           write_en,
  input  logic [ADDR_WIDTH-1:0]          write_addr,
  input  logic                           set_en,
  input  logic [ADDR_WIDTH-1:0]          set_addr,
  output logic [NUM_READ-1:0]            read_busy,
  output logic [ADDR_WIDTH:0]            busy_count,
  output logic                           any_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    count_q, count_d;
  logic             set_ok, inc, dec;

  always_comb begin
    // Register 0 is never marked when it is hard-wired to zero.
    set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));
    inc    = set_ok && (busy_q[set_addr] == BUSY_IDLE);
    // A write retires the producer only if no new producer lands on the same register.
    dec    = write_en && (busy_q[write_addr] == BUSY_PENDING)
             && !(set_ok && (set_addr == write_addr));

    busy_d = busy_q;
    if (write_en) busy_d[write_addr] = BUSY_IDLE;
    if (set_ok)   busy_d[set_addr]   = BUSY_PENDING;  // set wins over clear

    count_d = count_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // A same-cycle write hides busy; a same-cycle set only shows next cycle.
  always_comb begin
    read_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      read_busy[k] = busy_q[read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]]
                     && !(write_en && (write_addr == read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]));
    end
  end

  assign busy_count = count_q;
  assign any_busy   = (count_q != '0);

endmodule

// File: rtl/general_register_bank.sv
// rtl/general_register_bank.sv - multi-port register file with byte writes, bypass and busy scoreboard
//
// Purpose: register storage, byte-enable write port, write-first read bypass, busy tracking.
// Ports:
//   Clock            - rising-edge clock
//   CleanAllControl  - synchronous active-low reset (clears data, busy bits and count)
//   bus              - general_register_bank_if.slave (read/write/busy-set signals)

module general_register_bank
  import general_register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = GRB_DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = GRB_DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = GRB_DEFAULT_NUM_READ,
  parameter int ZERO_REG   = 1
) (
  input  logic                  Clock,
  input  logic                  CleanAllControl,
  general_register_bank_if.slave bus
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_BYTES = grb_num_bytes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  write_ok;
  logic [DATA_WIDTH-1:0] write_merged;

  // The merged value feeds both the storage update and the read bypass.
  always_comb begin
    write_ok     = bus.WriteControl && !((ZERO_REG != 0) && (bus.WriteRegAddress == '0));
    write_merged = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      write_merged[b*8 +: 8] = merge_byte(regs_q[bus.WriteRegAddress][b*8 +: 8],
                                          bus.DataOfWrite[b*8 +: 8],
                                          bus.WriteByteEnable[b]);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    if (write_ok) regs_d[bus.WriteRegAddress] = write_merged;
  end

  always_ff @(posedge Clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!CleanAllControl) regs_q[i] <= '0;
      else                  regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    bus.ReadData = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      if ((ZERO_REG != 0) && (bus.ReadAddresses[k*ADDR_WIDTH +: ADDR_WIDTH] == '0))
        bus.ReadData[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (write_ok && (bus.ReadAddresses[k*ADDR_WIDTH +: ADDR_WIDTH] == bus.WriteRegAddress))
        bus.ReadData[k*DATA_WIDTH +: DATA_WIDTH] = write_merged;
      else
        bus.ReadData[k*DATA_WIDTH +: DATA_WIDTH] =
          regs_q[bus.ReadAddresses[k*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  general_register_bank_busy_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .ZERO_REG   (ZERO_REG)
  ) u_busy_scoreboard (
    .clk        (Clock),
    .resetn     (CleanAllControl),
    .read_addr  (bus.ReadAddresses),
    .write_en   (bus.WriteControl),
    .write_addr (bus.WriteRegAddress),
    .set_en     (bus.BusySetControl),
    .set_addr   (bus.BusySetAddress),
    .read_busy  (bus.ReadBusy),
    .busy_count (bus.BusyCount),
    .any_busy   (bus.AnyBusy)
  );

endmodule

// File: tb/tb_general_register_bank.sv
// tb/tb_general_register_bank.sv - self-checking bench for general_register_bank

module tb_general_register_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  general_register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

  general_register_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1)
  ) dut (
    .Clock           (clk),
    .CleanAllControl (rstn),
    .bus             (bus.slave)
  );

  // Reference model: plain array of register values and a set of pending registers.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] obs_rd   [2];
  logic        obs_busy [2];
  logic [5:0]  obs_cnt;
  logic        obs_any;

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic int m_count();
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One clock: drive, check combinational outputs against the model, clock, update model.
  task automatic step(input bit rn, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input bit se, input logic [4:0] sa,
                      input logic [4:0] r0, input logic [4:0] r1);
    logic [4:0]  ra [2];
    logic [31:0] exp_rd;
    bit          exp_b;
    @(negedge clk);
    rstn                = rn;
    bus.WriteControl    = we;
    bus.WriteRegAddress = wa;
    bus.DataOfWrite     = wd;
    bus.WriteByteEnable = be;
    bus.BusySetControl  = se;
    bus.BusySetAddress  = sa;
    bus.ReadAddresses   = {r1, r0};
    #1;
    ra[0] = r0;
    ra[1] = r1;
    for (int k = 0; k < 2; k++) begin
      obs_rd[k]   = bus.ReadData[k*32 +: 32];
      obs_busy[k] = bus.ReadBusy[k];
      if (ra[k] == 5'd0)                exp_rd = 32'h0;
      else if (we && (ra[k] == wa))     exp_rd = m_merge(m_mem[ra[k]], wd, be);
      else                              exp_rd = m_mem[ra[k]];
      exp_b = m_busy[ra[k]] && !(we && (wa == ra[k]));
      check($sformatf("read_data%0d", k), 64'(obs_rd[k]), 64'(exp_rd));
      check($sformatf("read_busy%0d", k), 64'(obs_busy[k]), 64'(exp_b));
    end
    obs_cnt = bus.BusyCount;
    obs_any = bus.AnyBusy;
    check("busy_count", 64'(obs_cnt), 64'(m_count()));
    check("any_busy", 64'(obs_any), 64'(m_count() != 0));
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      if (we && (wa != 5'd0)) begin
        m_mem[wa]  = m_merge(m_mem[wa], wd, be);
        m_busy[wa] = 1'b0;
      end
      if (se && (sa != 5'd0)) m_busy[sa] = 1'b1;
    end
  endtask

  task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
    step(1, 0, 5'd0, 32'h0, 4'h0, 0, 5'd0, r0, r1);
  endtask

  initial begin
    logic [31:0] u;
    bit          rn, we, se;
    logic [4:0]  wa, sa, r0, r1;
    logic [31:0] wd;
    logic [3:0]  be;

    rstn                = 1'b0;
    bus.WriteControl    = 1'b0;
    bus.WriteRegAddress = '0;
    bus.DataOfWrite     = '0;
    bus.WriteByteEnable = '0;
    bus.BusySetControl  = 1'b0;
    bus.BusySetAddress  = '0;
    bus.ReadAddresses   = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state on every address.
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      check("reset_rd0", 64'(obs_rd[0]), 64'h0);
    end
    check("reset_count", 64'(obs_cnt), 64'h0);

    // Full write then single-byte write with bypass.
    step(1, 1, 5'd5, 32'hDEADBEEF, 4'b1111, 0, 5'd0, 5'd5, 5'd0);
    step(1, 1, 5'd5, 32'h00000011, 4'b0001, 0, 5'd0, 5'd5, 5'd1);
    check("bypass_r5", 64'(obs_rd[0]), 64'hDEADBE11);
    rd(5'd5, 5'd5);
    check("stored_r5", 64'(obs_rd[1]), 64'hDEADBE11);
    // All-zero mask leaves data alone.
    step(1, 1, 5'd5, 32'hFFFFFFFF, 4'b0000, 0, 5'd0, 5'd5, 5'd0);
    check("mask0_r5", 64'(obs_rd[0]), 64'hDEADBE11);

    // Register 0 is hard-wired.
    step(1, 1, 5'd0, 32'h12345678, 4'b1111, 0, 5'd0, 5'd0, 5'd0);
    check("r0_bypass", 64'(obs_rd[0]), 64'h0);
    step(1, 0, 5'd0, 32'h0, 4'h0, 1, 5'd0, 5'd0, 5'd0);
    check("r0_read", 64'(obs_rd[0]), 64'h0);
    rd(5'd0, 5'd0);
    check("r0_never_busy", 64'(obs_cnt), 64'h0);

    // Busy set / clear.
    step(1, 0, 5'd0, 32'h0, 4'h0, 1, 5'd3, 5'd3, 5'd0);
    check("set_not_visible", 64'(obs_busy[0]), 64'h0);
    step(1, 0, 5'd0, 32'h0, 4'h0, 1, 5'd7, 5'd3, 5'd7);
    rd(5'd3, 5'd7);
    check("count_two", 64'(obs_cnt), 64'd2);
    check("busy_r3", 64'(obs_busy[0]), 64'h1);
    step(1, 1, 5'd3, 32'hCAFEF00D, 4'b1111, 0, 5'd0, 5'd3, 5'd7);
    check("busy_r3_bypass", 64'(obs_busy[0]), 64'h0);
    rd(5'd3, 5'd7);
    check("count_one", 64'(obs_cnt), 64'd1);

    // Set and write to the same busy register.
    step(1, 0, 5'd0, 32'h0, 4'h0, 1, 5'd9, 5'd9, 5'd0);
    step(1, 1, 5'd9, 32'hA5A5A5A5, 4'b1111, 1, 5'd9, 5'd9, 5'd7);
    check("r9_count_before", 64'(obs_cnt), 64'd2);
    rd(5'd9, 5'd7);
    check("r9_still_busy", 64'(obs_busy[0]), 64'h1);
    check("r9_count_after", 64'(obs_cnt), 64'd2);
    check("r9_data", 64'(obs_rd[0]), 64'hA5A5A5A5);

    // Reset with writes and sets pending.
    step(1, 0, 5'd0, 32'h0, 4'h0, 1, 5'd11, 5'd11, 5'd9);
    step(0, 1, 5'd4, 32'h55555555, 4'b1111, 1, 5'd12, 5'd4, 5'd12);
    check("pre_reset_count", 64'(obs_cnt), 64'd3);
    rd(5'd5, 5'd9);
    check("post_reset_count", 64'(obs_cnt), 64'h0);
    check("post_reset_any", 64'(obs_any), 64'h0);
    check("post_reset_r5", 64'(obs_rd[0]), 64'h0);
    rd(5'd4, 5'd12);
    check("post_reset_r4", 64'(obs_rd[0]), 64'h0);

    // Randomised traffic, biased to a few registers to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      u  = $urandom_range(0, 59);  rn = (u != 0);
      u  = $urandom;               we = u[0]; se = u[1]; be = u[7:4];
      u  = $urandom;               wa = u[2] ? u[8:4] : {2'b00, u[14:12]};
      u  = $urandom;               sa = u[2] ? u[8:4] : {2'b00, u[14:12]};
      u  = $urandom;               r0 = u[1] ? wa : u[8:4];
                                   r1 = u[2] ? sa : {2'b00, u[14:12]};
      wd = $urandom;
      step(rn, we, wa, wd, be, se, sa, r0, r1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
